mod_exp: RTL and testbench
==========================

// Module: mod_exp
// PURPOSE
//   Iterative modular exponentiator: result = base^exponent mod modulo on 2*WIDTH-bit unsigned operands.
//   Start-by-reset: operands are captured while reset is high; computation runs after release.
//   finish flags completion. Serves as the RSA/crypto arithmetic core of the SHA-processor datapath.
// PARAMETERS
//   WIDTH  16  half operand width; all operands and result are N = 2*WIDTH bits
// PORTS (positional order: base, modulo, exponent, clk, reset, finish, result)
//   clk       in   1   single clock, rising edge
//   reset     in   1   synchronous, active-high; also acts as operand-load/start
//   base      in   N   base operand, unsigned
//   modulo    in   N   modulus, unsigned
//   exponent  in   N   exponent, unsigned
//   finish    out  1   high when result valid; held until next reset
//   result    out  N   base^exponent mod modulo
// BEHAVIOUR
//   - Reset (sync, active-high): finish=0, result=0, state=LOAD, cycle counters cleared.
//     base/modulo/exponent are latched on every clock edge while reset=1; input changes after release are ignored.
//   - States LOAD -> REDUCE -> EXP -> DONE. Cycle 1 = first edge with reset=0.
//   - REDUCE (N cycles): b = base mod modulo, computed as mod_mult(base, 1); acc = 1.
//   - EXP: right-to-left square-and-multiply over exponent bits LSB..MSB, one N-cycle step per bit.
//     Per step, two parallel mod_mult ops: if e[i] then acc = acc*b mod m; always b = b*b mod m.
//   - Fixed latency: all N exponent bits scanned; finish=1 and result=acc from the edge ending cycle N*(N+1)+1.
//     WIDTH=16: 1057 edges after reset release.
//   - DONE: finish and result hold until reset; no restart without reset.
//   - Corner cases: modulo==0 or modulo==1 -> result 0 (same latency).
//     exponent==0 and modulo>1 -> result 1. base>=modulo is legal (reduced in REDUCE).
//   - Reset mid-operation: aborts immediately, finish=0 next edge, operands re-latched.
//   - mod_mult(a,b,m), a,b<m: interleaved shift-add, MSB of a first, N cycles.
//     r = 2r (+b if a bit set), then conditional subtract of m up to twice.
//     Intermediate width N+2 bits; no overflow for any m<2^N.
// CONFIGURATION
//   MOD_EXP_EARLY_TERM_EN: when defined, EXP shifts the exponent right each step and
//     goes to DONE as soon as the remaining exponent is 0.
//     Latency becomes N*(1+k)+1, k = index of highest set bit + 1 (k=0 for exponent 0).
//     Results are identical either way.
//   Undefined (default): fixed latency N*(N+1)+1 regardless of operands.
// STRUCTURE
//   Shared package/header mod_exp_pkg: state encoding (LOAD, REDUCE, EXP, DONE) and derived constant N=2*WIDTH.
//   Sub-module mod_mult (params WIDTH; ports clk, reset, start, a, b, m, done, p), two instances (multiply, square).
//   Top holds the FSM, bit/cycle counters and operand registers.
// TESTING
//   WIDTH=16, base=3237, modulo=4171, exponent=2705, reset pulse -> finish=1 at edge 1057, result=159.
//   base=4, modulo=497, exponent=13 -> result=445; base=2, modulo=1000, exponent=10 -> result=24.
//   exponent=0, modulo=4171 -> result=1. modulo=1 -> result=0. base=0, exponent=5 -> result=0.
//   Reset asserted at cycle 500 mid-run with new operands (4,497,13) -> finish drops; new run ends with result=445.
//   Operand inputs changed after reset release -> result unaffected; finish/result stable for 100 cycles after DONE.
//   With MOD_EXP_EARLY_TERM_EN, (4,497,13) -> result 445 at edge N*5+1=161; random vectors match C model both builds.

Source files
------------

// File: rtl/mod_exp_pkg.sv
// Shared definitions for the modular exponentiator: FSM encoding and operand sizing.
// Included by mod_exp and mod_mult via import mod_exp_pkg::*.
package mod_exp_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        REDUCE = 2'd1,
        EXP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Full operand width is twice the half-width parameter.
    function automatic int op_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mod_mult.sv
// Interleaved shift-add modular multiplier p = a*b mod m, MSB of a first; N cycles, p/done valid combinationally in cycle N.
// No backpressure: start launches a new product, a/b/m must be held stable until done.
module mod_mult
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   a,
    input  logic [2*WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0]   m,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    localparam int N  = op_width(WIDTH);
    localparam int CW = $clog2(N) + 1;

    logic [N-1:0]  a_sh;
    logic [N-1:0]  r_q;
    logic [CW-1:0] cnt;
    logic          busy;

    logic [N-1:0]  r_cur;
    logic          a_bit;
    logic [N+1:0]  t0;
    logic [N+1:0]  t1;
    logic [N+1:0]  t2;
    logic [N+1:0]  m_ext;

    // The start cycle is the first of the N steps, so it works from r=0 and the live a input.
    always_comb begin
        r_cur = start ? '0 : r_q;
        a_bit = start ? a[N-1] : a_sh[N-1];
        m_ext = {2'b00, m};
        t0    = {1'b0, r_cur, 1'b0} + (a_bit ? {2'b00, b} : '0);
        t1    = (t0 >= m_ext) ? (t0 - m_ext) : t0;
        t2    = (t1 >= m_ext) ? (t1 - m_ext) : t1;
        p     = t2[N-1:0];
        done  = start ? (N == 1) : (busy && (cnt == CW'(N - 1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            r_q  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            a_sh <= a << 1;
            r_q  <= t2[N-1:0];
            cnt  <= CW'(1);
            busy <= (N != 1);
        end else if (busy) begin
            a_sh <= a_sh << 1;
            r_q  <= t2[N-1:0];
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mod_exp.sv
// Right-to-left square-and-multiply result = base^exponent mod modulo; start-by-reset, finish after N*(N+1)+1 cycles
// (N*(1+k)+1 with MOD_EXP_EARLY_TERM_EN). No backpressure: finish/result hold until the next reset.
module mod_exp
    import mod_exp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] base,
    input  logic [2*WIDTH-1:0] modulo,
    input  logic [2*WIDTH-1:0] exponent,
    input  logic               clk,
    input  logic               reset,
    output logic               finish,
    output logic [2*WIDTH-1:0] result
);

    localparam int N = op_width(WIDTH);

    state_t       state;
    state_t       state_nx;

    logic [N-1:0] base_q;
    logic [N-1:0] m_q;
    logic [N-1:0] e_q;
    logic [N-1:0] acc;
    logic [N-1:0] bb;
    logic         launch;

    logic [N-1:0] sq_a;
    logic [N-1:0] sq_b;
    logic [N-1:0] sq_p;
    logic [N-1:0] mul_p;
    logic         sq_done;
    logic         mul_done;
    logic         step_done;
    logic         last_step;
    logic         skip_exp;
    logic         degenerate;
    logic [N-1:0] acc_nx;

`ifdef MOD_EXP_EARLY_TERM_EN
    assign last_step = (e_q[N-1:1] == '0);
    assign skip_exp  = (e_q == '0);
`else
    localparam int BW = $clog2(N);
    logic [BW-1:0] bitcnt;

    assign last_step = (bitcnt == BW'(N - 1));
    assign skip_exp  = 1'b0;
`endif

    // The squaring unit doubles as the base reducer: base*1 mod m during REDUCE.
    assign sq_a       = (state == REDUCE) ? base_q : bb;
    assign sq_b       = (state == REDUCE) ? N'(1) : bb;
    assign step_done  = sq_done & mul_done;
    assign degenerate = (m_q <= N'(1));
    assign acc_nx     = e_q[0] ? mul_p : acc;

    mod_mult #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (launch),
        .a     (acc),
        .b     (bb),
        .m     (m_q),
        .done  (mul_done),
        .p     (mul_p)
    );

    mod_mult #(.WIDTH(WIDTH)) u_sq (
        .clk   (clk),
        .reset (reset),
        .start (launch),
        .a     (sq_a),
        .b     (sq_b),
        .m     (m_q),
        .done  (sq_done),
        .p     (sq_p)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    state_nx = REDUCE;
            REDUCE:  if (step_done) state_nx = skip_exp ? DONE : EXP;
            EXP:     if (step_done && last_step) state_nx = DONE;
            DONE:    state_nx = DONE;
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= base;
            m_q    <= modulo;
            e_q    <= exponent;
            acc    <= '0;
            bb     <= '0;
            launch <= 1'b0;
            finish <= 1'b0;
            result <= '0;
`ifndef MOD_EXP_EARLY_TERM_EN
            bitcnt <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    acc    <= N'(1);
                    launch <= 1'b1;
                end
                REDUCE: begin
                    launch <= 1'b0;
                    if (step_done) begin
                        bb <= sq_p;
                        if (skip_exp) begin
                            finish <= 1'b1;
                            result <= degenerate ? '0 : acc;
                        end else begin
                            launch <= 1'b1;
                        end
                    end
                end
                EXP: begin
                    launch <= 1'b0;
                    if (step_done) begin
                        acc <= acc_nx;
                        bb  <= sq_p;
                        e_q <= e_q >> 1;
`ifndef MOD_EXP_EARLY_TERM_EN
                        bitcnt <= bitcnt + BW'(1);
`endif
                        if (last_step) begin
                            finish <= 1'b1;
                            result <= degenerate ? '0 : acc_nx;
                        end else begin
                            launch <= 1'b1;
                        end
                    end
                end
                default: begin
                    launch <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_exp.sv
// Scoreboard bench for mod_exp: expected results queued at stimulus, checked when finish rises.
module tb_mod_exp;

    localparam int WIDTH = 16;
    localparam int N     = 2 * WIDTH;
    localparam int LIMIT = N * (N + 1) + 50;

    logic          clk;
    logic          reset;
    logic [N-1:0]  base;
    logic [N-1:0]  modulo;
    logic [N-1:0]  exponent;
    logic          finish;
    logic [N-1:0]  result;

    int            n_cmp;
    int            n_bad;
    logic [N-1:0]  exp_q[$];

    mod_exp #(.WIDTH(WIDTH)) dut (
        .base     (base),
        .modulo   (modulo),
        .exponent (exponent),
        .clk      (clk),
        .reset    (reset),
        .finish   (finish),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] b, input logic [N-1:0] m,
                                           input logic [N-1:0] e);
        longint unsigned r, x, mm;
        if (m <= 1) return '0;
        mm = 64'(m);
        r  = 1;
        x  = 64'(b) % mm;
        for (int i = 0; i < N; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return N'(r);
    endfunction

    function automatic int latency(input logic [N-1:0] e);
`ifdef MOD_EXP_EARLY_TERM_EN
        int k;
        k = 0;
        for (int i = 0; i < N; i++) if (e[i]) k = i + 1;
        return N * (1 + k) + 1;
`else
        return N * (N + 1) + 1;
`endif
    endfunction

    // Load operands under a one-edge reset pulse; on return the next edge is cycle 1.
    task automatic load(input logic [N-1:0] b, input logic [N-1:0] m, input logic [N-1:0] e);
        base     = b;
        modulo   = m;
        exponent = e;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        check("rst_finish", 64'(finish), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        reset = 1'b0;
    endtask

    // Wait for finish, scrambling the operand inputs after release, then score latency and result.
    task automatic await(input string tag, input int lat);
        int edges;
        logic [N-1:0] want;
        edges = 0;
        while (!finish && edges < LIMIT) begin
            @(posedge clk);
            #1;
            edges++;
            if (edges == 1) begin
                base     = $urandom;
                modulo   = $urandom;
                exponent = $urandom;
            end
        end
        check({tag, "_finish"}, 64'(finish), 64'd1);
        check({tag, "_latency"}, 64'(edges), 64'(lat));
        want = exp_q.pop_front();
        check({tag, "_result"}, 64'(result), 64'(want));
    endtask

    task automatic run(input string tag, input logic [N-1:0] b, input logic [N-1:0] m,
                       input logic [N-1:0] e, input logic [N-1:0] want);
        exp_q.push_back(want);
        load(b, m, e);
        await(tag, latency(e));
    endtask

    initial begin
        logic [N-1:0] rb, rm, re, held;
        n_cmp    = 0;
        n_bad    = 0;
        reset    = 1'b1;
        base     = '0;
        modulo   = '0;
        exponent = '0;
        repeat (3) @(posedge clk);
        #1;
        check("init_finish", 64'(finish), 64'd0);
        check("init_result", 64'(result), 64'd0);

        run("rsa",    32'd3237, 32'd4171, 32'd2705, 32'd159);
        run("small",  32'd4,    32'd497,  32'd13,   32'd445);
        run("pow2",   32'd2,    32'd1000, 32'd10,   32'd24);
        run("exp0",   32'd3237, 32'd4171, 32'd0,    32'd1);
        run("mod1",   32'd3237, 32'd1,    32'd2705, 32'd0);
        run("mod0",   32'd55,   32'd0,    32'd7,    32'd0);
        run("base0",  32'd0,    32'd4171, 32'd5,    32'd0);
        run("bigb",   32'hFFFF_FFFF, 32'd4171, 32'd2705, model(32'hFFFF_FFFF, 32'd4171, 32'd2705));
        run("bigm",   32'hDEAD_BEEF, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
            model(32'hDEAD_BEEF, 32'hFFFF_FFFB, 32'hFFFF_FFFF));

        // finish/result must hold steady after DONE
        held = result;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (i % 10 == 9) begin
                check("hold_finish", 64'(finish), 64'd1);
                check("hold_result", 64'(result), 64'(held));
            end
        end

        // abort mid-run with new operands
        exp_q.push_back(model(32'd3237, 32'd4171, 32'd2705));
        load(32'd3237, 32'd4171, 32'd2705);
        repeat (500) @(posedge clk);
        #1;
        check("mid_finish", 64'(finish), 64'd0);
        void'(exp_q.pop_back());
        exp_q.push_back(32'd445);
        load(32'd4, 32'd497, 32'd13);
        await("abort", latency(32'd13));

        for (int i = 0; i < 6; i++) begin
            rb = $urandom;
            rm = (i % 2 == 0) ? 32'($urandom_range(2, 65535)) : $urandom;
            re = (i == 5) ? 32'($urandom_range(0, 255)) : $urandom;
            run("rand", rb, rm, re, model(rb, rm, re));
        end

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
